// File: rtl/alu_share_ctrl.sv
// Shares one combinational 8-bit ALU between two requesters with round-robin grant and one tagged response.
// Optional feature: define ALU_SHARE_STATS_EN to add saturating stat_ops / stat_conflicts counters.
module alu_share_ctrl #(
  parameter int PRIO_INIT = 0,
  parameter int DATA_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2:0]            req0_op,
  input  logic [DATA_W-1:0]     req0_a,
  input  logic [DATA_W-1:0]     req0_b,
  input  logic                  req0_cin,
  input  logic                  req0_bin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2:0]            req1_op,
  input  logic [DATA_W-1:0]     req1_a,
  input  logic [DATA_W-1:0]     req1_b,
  input  logic                  req1_cin,
  input  logic                  req1_bin,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic                  alu_cin,
  output logic                  alu_bin,
  output logic [4:0]            alu_sel,
  input  logic [2*DATA_W-1:0]   alu_z,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  input  logic                  alu_negative,
  input  logic                  alu_zero,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [2*DATA_W-1:0]   resp_z,
  output logic [3:0]            resp_flags,
  output logic                  resp_err
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_conflicts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_RESP} state_t;

  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  state_t              state;
  state_t              state_nxt;
  logic                prio;
  logic                gnt_any;
  logic                gnt_id;
  logic                accept;
  logic [2:0]          sel_op;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                sel_cin;
  logic                sel_bin;
  logic                id_p0;
  logic                err_p0;

  function automatic logic [4:0] enc_sel(input logic [2:0] op);
    case (op)
      3'd0:    enc_sel = 5'b00001;
      3'd1:    enc_sel = 5'b00010;
      3'd2:    enc_sel = 5'b00100;
      3'd3:    enc_sel = 5'b01000;
      3'd4:    enc_sel = 5'b10000;
      3'd5:    enc_sel = 5'b00000;
      3'd6:    enc_sel = 5'b00101;
      default: enc_sel = 5'b00000;
    endcase
  endfunction

`ifdef ALU_SHARE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // A lone requester wins outright; on a tie the priority owner wins.
  always_comb begin
    gnt_id = prio;
    if (req0_valid && !req1_valid) begin
      gnt_id = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign gnt_any = req0_valid | req1_valid;
  assign accept  = (state == S_IDLE) && gnt_any && !rst;

  always_comb begin
    sel_op  = req0_op;
    sel_a   = req0_a;
    sel_b   = req0_b;
    sel_cin = req0_cin;
    sel_bin = req0_bin;
    if (gnt_id) begin
      sel_op  = req1_op;
      sel_a   = req1_a;
      sel_b   = req1_b;
      sel_cin = req1_cin;
      sel_bin = req1_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt_any) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req0_ready = !rst && gnt_any && !gnt_id;
        req1_ready = !rst && gnt_any && gnt_id;
      end
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: operands registered toward the ALU on accept, held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio    <= 1'(PRIO_INIT);
      id_p0   <= 1'b0;
      err_p0  <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
      alu_bin <= 1'b0;
      alu_sel <= 5'b00000;
    end else if (accept) begin
      prio    <= ~gnt_id;
      id_p0   <= gnt_id;
      err_p0  <= (sel_op == OP_ILLEGAL);
      alu_a   <= sel_a;
      alu_b   <= sel_b;
      alu_cin <= sel_cin;
      alu_bin <= sel_bin;
      alu_sel <= enc_sel(sel_op);
    end
  end

  // Stage p1: the ALU has settled for a full cycle; capture result at the end of CAPT.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_id    <= 1'b0;
      resp_z     <= '0;
      resp_flags <= 4'b0000;
      resp_err   <= 1'b0;
    end else if (state == S_CAPT) begin
      resp_id    <= id_p0;
      resp_err   <= err_p0;
      resp_z     <= err_p0 ? '0 : alu_z;
      resp_flags <= err_p0 ? 4'b0000 : {alu_carry, alu_overflow, alu_negative, alu_zero};
    end
  end

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops       <= 16'd0;
      stat_conflicts <= 16'd0;
    end else begin
      if (resp_valid && resp_ready) stat_ops <= sat_inc(stat_ops);
      if ((state == S_IDLE) && req0_valid && req1_valid) stat_conflicts <= sat_inc(stat_conflicts);
    end
  end
`endif

  a_one_grant: assert property (@(posedge clk) disable iff (rst) !(req0_ready && req1_ready));
  a_resp_hold: assert property (@(posedge clk) disable iff (rst)
                 (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_z) && $stable(resp_id)));

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: behavioural ALU, transaction-level scoreboard, directed vectors.
module tb_alu_share_ctrl;
  localparam int PRIO_INIT = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin, req0_bin;
  logic [2:0]  req0_op;
  logic [7:0]  req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin, req1_bin;
  logic [2:0]  req1_op;
  logic [7:0]  req1_a, req1_b;
  logic [7:0]  alu_a, alu_b;
  logic        alu_cin, alu_bin;
  logic [4:0]  alu_sel;
  logic [15:0] alu_z;
  logic        alu_carry, alu_overflow, alu_negative, alu_zero;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [15:0] resp_z;
  logic [3:0]  resp_flags;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0] stat_ops, stat_conflicts;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.PRIO_INIT(PRIO_INIT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_bin(req0_bin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_bin(req1_bin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_bin(alu_bin), .alu_sel(alu_sel),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_z(resp_z), .resp_flags(resp_flags), .resp_err(resp_err)
`ifdef ALU_SHARE_STATS_EN
    , .stat_ops(stat_ops), .stat_conflicts(stat_conflicts)
`endif
  );

  // Operation semantics by opcode: returns {carry, overflow, negative, zero, z[15:0]}.
  function automatic logic [19:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic bin);
    logic [8:0]         s;
    logic [15:0]        z;
    logic signed [15:0] sp;
    logic               c, v, n;
    s = 9'd0; z = 16'd0; sp = 16'sd0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        z = {8'h00, s[7:0]}; c = s[8]; v = (a[7] == b[7]) && (s[7] != a[7]);
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b} - {8'd0, bin};
        z = {8'h00, s[7:0]}; c = s[8]; v = (a[7] != b[7]) && (s[7] != a[7]);
      end
      3'd2: z = {8'h00, a & b};
      3'd3: z = {8'h00, a | b};
      3'd4: z = {8'h00, a ^ b};
      3'd5: z = {8'h00, a} * {8'h00, b};
      3'd6: begin
        sp = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
        z = sp;
      end
      default: z = 16'd0;
    endcase
    n = (op == 3'd5 || op == 3'd6) ? z[15] : z[7];
    ref_op = {c, v, n, (z == 16'd0), z};
  endfunction

  // Expected response: {err, flags[3:0], z[15:0]}.
  function automatic logic [20:0] exp_resp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic bin);
    if (op == 3'd7) exp_resp = {1'b1, 20'd0};
    else            exp_resp = {1'b0, ref_op(op, a, b, cin, bin)};
  endfunction

  // Behavioural shared ALU driven by the controller's select code.
  logic [2:0]  alu_dop;
  logic        alu_known;
  logic [19:0] alu_r;
  always_comb begin
    alu_dop   = 3'd0;
    alu_known = 1'b1;
    case (alu_sel)
      5'b00001: alu_dop = 3'd0;
      5'b00010: alu_dop = 3'd1;
      5'b00100: alu_dop = 3'd2;
      5'b01000: alu_dop = 3'd3;
      5'b10000: alu_dop = 3'd4;
      5'b00000: alu_dop = 3'd5;
      5'b00101: alu_dop = 3'd6;
      default:  alu_known = 1'b0;
    endcase
    alu_r = ref_op(alu_dop, alu_a, alu_b, alu_cin, alu_bin);
    if (!alu_known) alu_r = {4'hF, 16'hDEAD};
    alu_z = alu_r[15:0];
    {alu_carry, alu_overflow, alu_negative, alu_zero} = alu_r[19:16];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: one outstanding transaction, response due two edges after the accepting edge.
  logic        m_pend;
  int          m_age;
  logic        m_id;
  logic        m_prio;
  logic [20:0] m_exp;
  int          m_ops, m_conf;

  function automatic logic grant_of(input logic v0, input logic v1, input logic p);
    grant_of = (v0 && v1) ? p : v1;
  endfunction

  function automatic logic exp_rdy(input int n, input logic r, input logic pend,
                                   input logic v0, input logic v1, input logic p);
    if (r || pend || !(v0 || v1)) exp_rdy = 1'b0;
    else                          exp_rdy = (grant_of(v0, v1, p) == (n != 0));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0; m_age <= 0; m_id <= 1'b0; m_prio <= 1'(PRIO_INIT);
      m_exp <= '0; m_ops <= 0; m_conf <= 0;
    end else if (!m_pend) begin
      if (req0_valid && req1_valid && m_conf < 65535) m_conf <= m_conf + 1;
      if (req0_valid || req1_valid) begin
        m_pend <= 1'b1;
        m_age  <= 0;
        m_id   <= grant_of(req0_valid, req1_valid, m_prio);
        m_prio <= ~grant_of(req0_valid, req1_valid, m_prio);
        m_exp  <= grant_of(req0_valid, req1_valid, m_prio)
                  ? exp_resp(req1_op, req1_a, req1_b, req1_cin, req1_bin)
                  : exp_resp(req0_op, req0_a, req0_b, req0_cin, req0_bin);
      end
    end else if (m_age >= 2 && resp_ready) begin
      m_pend <= 1'b0;
      if (m_ops < 65535) m_ops <= m_ops + 1;
    end else if (m_age < 2) begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req0_ready", 32'(req0_ready), 32'(exp_rdy(0, rst, m_pend, req0_valid, req1_valid, m_prio)));
      chk("req1_ready", 32'(req1_ready), 32'(exp_rdy(1, rst, m_pend, req0_valid, req1_valid, m_prio)));
      chk("resp_valid", 32'(resp_valid), 32'(m_pend && m_age >= 2));
      if (m_pend && m_age >= 2) begin
        chk("resp_id", 32'(resp_id), 32'(m_id));
        chk("resp_z", 32'(resp_z), 32'(m_exp[15:0]));
        chk("resp_flags", 32'(resp_flags), 32'(m_exp[19:16]));
        chk("resp_err", 32'(resp_err), 32'(m_exp[20]));
      end
`ifdef ALU_SHARE_STATS_EN
      chk("stat_ops", 32'(stat_ops), 32'(m_ops));
      chk("stat_conflicts", 32'(stat_conflicts), 32'(m_conf));
`endif
    end
  end

  task automatic issue(input bit n, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic bin);
    int ok;
    ok = 0;
    if (!n) begin
      req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; req0_bin = bin; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; req1_bin = bin; req1_valid = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((n ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!n) req0_valid = 1'b0;
    else    req1_valid = 1'b0;
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("resp_timeout", 32'(lat != 0), 32'd1);
  endtask

  typedef struct packed {
    logic       n;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       bin;
    logic [15:0] z;
    logic [3:0] flags;
  } vec_t;

  vec_t vt[10];
  int   lat;
  int   nid;
  logic ids[4];

  initial begin
    vt[0] = '{1'b0, 3'd0, 8'hFF, 8'h01, 1'b1, 1'b0, 16'h0001, 4'b1000};
    vt[1] = '{1'b1, 3'd1, 8'h00, 8'h01, 1'b0, 1'b0, 16'h00FF, 4'b1010};
    vt[2] = '{1'b0, 3'd1, 8'h80, 8'h01, 1'b0, 1'b0, 16'h007F, 4'b0100};
    vt[3] = '{1'b1, 3'd2, 8'hF0, 8'h3C, 1'b0, 1'b0, 16'h0030, 4'b0000};
    vt[4] = '{1'b0, 3'd3, 8'hF0, 8'h0F, 1'b0, 1'b0, 16'h00FF, 4'b0010};
    vt[5] = '{1'b1, 3'd4, 8'hAA, 8'hAA, 1'b0, 1'b0, 16'h0000, 4'b0001};
    vt[6] = '{1'b0, 3'd6, 8'h80, 8'h80, 1'b0, 1'b0, 16'h4000, 4'b0000};
    vt[7] = '{1'b1, 3'd5, 8'h00, 8'h55, 1'b0, 1'b0, 16'h0000, 4'b0001};
    vt[8] = '{1'b0, 3'd6, 8'h7F, 8'hFF, 1'b0, 1'b0, 16'hFF81, 4'b0010};
    vt[9] = '{1'b1, 3'd1, 8'h05, 8'h03, 1'b0, 1'b1, 16'h0001, 4'b0000};

    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = 8'h00; req0_b = 8'h00; req0_cin = 1'b0; req0_bin = 1'b0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b0; req1_bin = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_z", 32'(resp_z), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);

    // Both requesters valid every cycle: grants alternate starting from PRIO_INIT.
    @(posedge clk); #1;
    rst = 1'b0;
    req0_op = 3'd0; req0_a = 8'h10; req0_b = 8'h20; req0_valid = 1'b1;
    req1_op = 3'd1; req1_a = 8'h50; req1_b = 8'h05; req1_valid = 1'b1;
    nid = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1 && nid < 4) begin
        ids[nid] = resp_id;
        nid++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rr_count", 32'(nid), 32'd4);
    chk("rr_id0", 32'(ids[0]), 32'd0);
    chk("rr_id1", 32'(ids[1]), 32'd1);
    chk("rr_id2", 32'(ids[2]), 32'd0);
    chk("rr_id3", 32'(ids[3]), 32'd1);

    // ADD overflow case, with latency and select encoding pinned.
    issue(1'b0, 3'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
    chk("add_sel", 32'(alu_sel), 32'h01);
    chk("add_alu_a", 32'(alu_a), 32'h7F);
    wait_resp(lat);
    chk("add_latency", 32'(lat), 32'd3);
    chk("add_id", 32'(resp_id), 32'd0);
    chk("add_z", 32'(resp_z), 32'h0080);
    chk("add_flags", 32'(resp_flags), 32'b0110);
    chk("add_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;

    issue(1'b1, 3'd6, 8'hFF, 8'h02, 1'b0, 1'b0);
    chk("smul_sel", 32'(alu_sel), 32'h05);
    wait_resp(lat);
    chk("smul_id", 32'(resp_id), 32'd1);
    chk("smul_z", 32'(resp_z), 32'hFFFE);
    chk("smul_flags", 32'(resp_flags), 32'b0010);
    @(posedge clk); #1;

    issue(1'b1, 3'd5, 8'hFF, 8'h02, 1'b0, 1'b0);
    wait_resp(lat);
    chk("umul_z", 32'(resp_z), 32'h01FE);
    chk("umul_flags", 32'(resp_flags), 32'b0000);
    @(posedge clk); #1;

    issue(1'b0, 3'd7, 8'h12, 8'h34, 1'b1, 1'b1);
    wait_resp(lat);
    chk("ill_err", 32'(resp_err), 32'd1);
    chk("ill_z", 32'(resp_z), 32'd0);
    chk("ill_flags", 32'(resp_flags), 32'd0);
    @(posedge clk); #1;

    foreach (vt[i]) begin
      issue(vt[i].n, vt[i].op, vt[i].a, vt[i].b, vt[i].cin, vt[i].bin);
      wait_resp(lat);
      chk($sformatf("vec%0d_z", i), 32'(resp_z), 32'(vt[i].z));
      chk($sformatf("vec%0d_flags", i), 32'(resp_flags), 32'(vt[i].flags));
      @(posedge clk); #1;
    end

    // Consumer stalls five cycles while the other requester waits.
    resp_ready = 1'b0;
    issue(1'b0, 3'd4, 8'h5A, 8'h0F, 1'b0, 1'b0);
    wait_resp(lat);
    @(posedge clk); #1;
    req1_op = 3'd0; req1_a = 8'h01; req1_b = 8'h02; req1_cin = 1'b0; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_z", 32'(resp_z), 32'h0055);
      chk("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    issue(1'b1, 3'd0, 8'h01, 8'h02, 1'b0, 1'b0);
    wait_resp(lat);
    chk("after_stall_z", 32'(resp_z), 32'h0003);
    chk("after_stall_id", 32'(resp_id), 32'd1);
    @(posedge clk); #1;

    // A request raised and withdrawn while busy must leave no trace.
    issue(1'b0, 3'd3, 8'h0C, 8'h30, 1'b0, 1'b0);
    req1_op = 3'd1; req1_a = 8'h99; req1_b = 8'h11; req1_valid = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_resp(lat);
    chk("drop_z", 32'(resp_z), 32'h003C);
    chk("drop_id", 32'(resp_id), 32'd0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    // Reset during EXEC discards the operation.
    issue(1'b0, 3'd0, 8'h11, 8'h22, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("mid_rst_resp_z", 32'(resp_z), 32'd0);
    chk("mid_rst_flags", 32'(resp_flags), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
